// File: rtl/adc_calib_pkg.sv
// ---------------------------------------------------------------------------
// adc_calib_pkg
//   Shared definitions for the ADC input-delay tap calibration block:
//   FSM state encoding, tap/eye widths, default parameter values and the
//   helper that places the final tap in the centre of the passing window.
// ---------------------------------------------------------------------------
package adc_calib_pkg;

    // Delay-line geometry
    localparam int TAP_W   = 5;
    localparam int TAP_MAX = 31;
    localparam int EYE_W   = 6;          // holds 0..32

    // Internal cycle counter width (settle / check / timeout)
    localparam int CNT_W   = 16;

    // Parameter defaults for adc_tap_calib
    localparam logic [15:0] PATTERN_DEF     = 16'hA55A;
    localparam int          SETTLE_CYC_DEF  = 8;
    localparam int          SAMPLE_CNT_DEF  = 16;
    localparam int          MIN_EYE_DEF     = 4;
    localparam int          TIMEOUT_CYC_DEF = 255;

    typedef logic [TAP_W-1:0] tap_t;
    typedef logic [EYE_W-1:0] eye_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SET,
        ST_SETTLE,
        ST_CHECK,
        ST_NEXT,
        ST_FINISH
    } cal_state_t;

    // Centre of a window: start + floor(len/2), saturated at the last tap.
    function automatic tap_t eye_center(input tap_t start, input eye_t len);
        logic [EYE_W:0] sum;
        sum = {2'b00, start} + {1'b0, len >> 1};
        if (sum > (EYE_W+1)'(TAP_MAX))
            return tap_t'(TAP_MAX);
        return sum[TAP_W-1:0];
    endfunction

endpackage : adc_calib_pkg

// File: rtl/adc_eye_tracker.sv
// ---------------------------------------------------------------------------
// adc_eye_tracker
//   Tracks the longest run of consecutive passing taps during a sweep.
//   Results arrive in tap order (0, 1, 2, ...), one per 'valid' pulse, so
//   the tracker keeps its own tap index rather than taking one as input.
//
//   Ports
//     clk        : clock, rising edge
//     rst        : asynchronous active-high reset
//     valid      : one result for the next tap is presented this cycle
//     pass       : that tap passed (qualified by valid)
//     clear      : synchronous clear before a new sweep
//     close      : end of sweep; an open run is folded into the best
//     best_start : first tap of the best window
//     best_len   : width of the best window, in taps (0..32)
//
//   While 'close' is high the outputs already reflect the closed run, so
//   the caller can latch the final answer in that same cycle.
// ---------------------------------------------------------------------------
module adc_eye_tracker
    import adc_calib_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic valid,
    input  logic pass,
    input  logic clear,
    input  logic close,
    output tap_t best_start,
    output eye_t best_len
);

    tap_t idx;
    tap_t run_start;
    eye_t run_len;
    tap_t best_start_q;
    eye_t best_len_q;
    logic run_wins;

    // Strictly longer only: on a tie the earlier window stays the best.
    assign run_wins   = (run_len > best_len_q);

    assign best_start = (close && run_wins) ? run_start : best_start_q;
    assign best_len   = (close && run_wins) ? run_len   : best_len_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx          <= '0;
            run_start    <= '0;
            run_len      <= '0;
            best_start_q <= '0;
            best_len_q   <= '0;
        end else if (clear) begin
            idx          <= '0;
            run_start    <= '0;
            run_len      <= '0;
            best_start_q <= '0;
            best_len_q   <= '0;
        end else if (valid) begin
            idx <= idx + 1'b1;
            if (pass) begin
                if (run_len == '0)
                    run_start <= idx;
                run_len <= run_len + 1'b1;
            end else begin
                if (run_wins) begin
                    best_start_q <= run_start;
                    best_len_q   <= run_len;
                end
                run_len <= '0;
            end
        end else if (close) begin
            // A run reaching the last tap never saw a failing tap to end it.
            if (run_wins) begin
                best_start_q <= run_start;
                best_len_q   <= run_len;
            end
            run_len <= '0;
        end
    end

endmodule : adc_eye_tracker

// File: rtl/adc_tap_calib.sv
// ---------------------------------------------------------------------------
// adc_tap_calib
//   Sweeps a shared input-delay tap across all 32 settings, checks the four
//   deserialised ADC channels against a training word at each tap, finds
//   the widest passing window and parks the delay line in its centre.
//
//   Per tap: SET (1 cycle) -> SETTLE (>= SETTLE_CYC cycles, until the tap
//   readback matches) -> CHECK (exactly SAMPLE_CNT cycles) -> NEXT (1).
//   After tap 31, FINISH (1 cycle) decides DONE or FAIL.
//
//   Ports
//     CLK_DIV_IN       : only clock, rising edge
//     IO_RESET         : asynchronous active-high reset
//     START            : one-cycle calibration request (accepted in IDLE)
//     CH1..CH4_DATA    : deserialised 16-bit ADC words
//     IN_DELAY_TAP_OUT : tap value read back from the delay lines
//     IN_DELAY_TAP_IN  : commanded tap, common to all channels
//     BUSY             : sweep in progress
//     DONE / FAIL      : sticky result levels, cleared by the next START
//     EYE_WIDTH        : width of the best passing window (0..32)
// ---------------------------------------------------------------------------
module adc_tap_calib
    import adc_calib_pkg::*;
#(
    parameter logic [15:0] PATTERN     = PATTERN_DEF,
    parameter int          SETTLE_CYC  = SETTLE_CYC_DEF,
    parameter int          SAMPLE_CNT  = SAMPLE_CNT_DEF,
    parameter int          MIN_EYE     = MIN_EYE_DEF,
    parameter int          TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic             CLK_DIV_IN,
    input  logic             IO_RESET,
    input  logic             START,
    input  logic [15:0]      CH1_DATA,
    input  logic [15:0]      CH2_DATA,
    input  logic [15:0]      CH3_DATA,
    input  logic [15:0]      CH4_DATA,
    input  logic [TAP_W-1:0] IN_DELAY_TAP_OUT,
    output logic [TAP_W-1:0] IN_DELAY_TAP_IN,
    output logic             BUSY,
    output logic             DONE,
    output logic             FAIL,
    output logic [EYE_W-1:0] EYE_WIDTH
);

    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] SAMPLE_LAST  = CNT_W'(SAMPLE_CNT - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    cal_state_t       state;
    tap_t             tap;
    logic [CNT_W-1:0] cnt;
    logic             tap_pass;

    logic             words_ok;
    logic             readback_ok;

    logic             trk_valid;
    logic             trk_clear;
    logic             trk_close;
    tap_t             best_start;
    eye_t             best_len;

    assign words_ok    = (CH1_DATA == PATTERN) && (CH2_DATA == PATTERN) &&
                         (CH3_DATA == PATTERN) && (CH4_DATA == PATTERN);
    assign readback_ok = (IN_DELAY_TAP_OUT == tap);

    assign trk_valid   = (state == ST_NEXT);
    assign trk_clear   = (state == ST_IDLE) && START;
    assign trk_close   = (state == ST_FINISH);

    adc_eye_tracker u_tracker (
        .clk        (CLK_DIV_IN),
        .rst        (IO_RESET),
        .valid      (trk_valid),
        .pass       (tap_pass),
        .clear      (trk_clear),
        .close      (trk_close),
        .best_start (best_start),
        .best_len   (best_len)
    );

    // NOTE: every register here, outputs included, is cleared by the async
    // reset, and all state updates use non-blocking assignments so that
    // every branch reads the pre-edge values of the other registers.
    always_ff @(posedge CLK_DIV_IN or posedge IO_RESET) begin
        if (IO_RESET) begin
            state           <= ST_IDLE;
            tap             <= '0;
            cnt             <= '0;
            tap_pass        <= 1'b0;
            IN_DELAY_TAP_IN <= '0;
            BUSY            <= 1'b0;
            DONE            <= 1'b0;
            FAIL            <= 1'b0;
            EYE_WIDTH       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (START) begin
                        DONE            <= 1'b0;
                        FAIL            <= 1'b0;
                        EYE_WIDTH       <= '0;
                        tap             <= '0;
                        IN_DELAY_TAP_IN <= '0;
                        BUSY            <= 1'b1;
                        state           <= ST_SET;
                    end
                end

                ST_SET: begin
                    cnt   <= '0;
                    state <= ST_SETTLE;
                end

                ST_SETTLE: begin
                    // A matching readback on the final allowed cycle still
                    // counts, so it is tested before the timeout.
                    if ((cnt >= SETTLE_LAST) && readback_ok) begin
                        cnt      <= '0;
                        tap_pass <= 1'b1;
                        state    <= ST_CHECK;
                    end else if (cnt == TIMEOUT_LAST) begin
                        FAIL            <= 1'b1;
                        IN_DELAY_TAP_IN <= '0;
                        BUSY            <= 1'b0;
                        state           <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ST_CHECK: begin
                    // Runs the full window even after a miss.
                    tap_pass <= tap_pass & words_ok;
                    if (cnt == SAMPLE_LAST)
                        state <= ST_NEXT;
                    else
                        cnt <= cnt + 1'b1;
                end

                ST_NEXT: begin
                    if (tap == tap_t'(TAP_MAX)) begin
                        state <= ST_FINISH;
                    end else begin
                        tap             <= tap + 1'b1;
                        IN_DELAY_TAP_IN <= tap + 1'b1;
                        state           <= ST_SET;
                    end
                end

                ST_FINISH: begin
                    EYE_WIDTH <= best_len;
                    if (best_len >= EYE_W'(MIN_EYE)) begin
                        IN_DELAY_TAP_IN <= eye_center(best_start, best_len);
                        DONE            <= 1'b1;
                    end else begin
                        IN_DELAY_TAP_IN <= '0;
                        FAIL            <= 1'b1;
                    end
                    BUSY  <= 1'b0;
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

    // DONE and FAIL are two outcomes of one sweep and never coexist.
    a_done_fail_excl: assert property (
        @(posedge CLK_DIV_IN) disable iff (IO_RESET) !(DONE && FAIL)
    );

endmodule : adc_tap_calib

// File: tb/tb_adc_tap_calib.sv
// ---------------------------------------------------------------------------
// tb_adc_tap_calib
//   Self-checking bench for adc_tap_calib. An ADC model drives the channel
//   words from the tap readback and a per-tap pass mask; the readback
//   follows the commanded tap after a configurable lag. Each calibration
//   run pushes its expected outcome into a scoreboard; a monitor pops and
//   compares whenever BUSY falls.
// ---------------------------------------------------------------------------
module tb_adc_tap_calib;

    localparam logic [15:0] PAT = 16'hA55A;

    typedef struct {
        bit done;
        bit fail;
        int tap;
        int eye;
        int busy;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] ch1, ch2, ch3, ch4;
    logic [4:0]  tap_out;
    logic [4:0]  tap_in;
    logic        busy;
    logic        done;
    logic        fail_o;
    logic [5:0]  eye;

    int n_tests = 0;
    int n_fail  = 0;
    int results_seen = 0;

    exp_t sb_q[$];

    // ADC environment controls
    logic [31:0] pass_mask = 32'hFFFF_FFFF;
    bit          glitch12  = 0;
    int          lag       = 0;
    bit          stuck     = 0;

    adc_tap_calib dut (
        .CLK_DIV_IN       (clk),
        .IO_RESET         (rst),
        .START            (start),
        .CH1_DATA         (ch1),
        .CH2_DATA         (ch2),
        .CH3_DATA         (ch3),
        .CH4_DATA         (ch4),
        .IN_DELAY_TAP_OUT (tap_out),
        .IN_DELAY_TAP_IN  (tap_in),
        .BUSY             (busy),
        .DONE             (done),
        .FAIL             (fail_o),
        .EYE_WIDTH        (eye)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        n_tests++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Reference: longest run of set bits in the mask (earliest on a tie),
    // centre tap, and sweep length from 32 taps of 1+settle+16+1 cycles.
    function automatic exp_t model(input logic [31:0] mask, input int lg);
        exp_t e;
        int bs = 0, bl = 0, rs = 0, rl = 0;
        for (int t = 0; t < 32; t++) begin
            if (mask[t]) begin
                if (rl == 0) rs = t;
                rl++;
                if (rl > bl) begin
                    bl = rl;
                    bs = rs;
                end
            end else begin
                rl = 0;
            end
        end
        e.eye  = bl;
        e.done = (bl >= 4);
        e.fail = !e.done;
        e.tap  = e.done ? ((bs + bl / 2 > 31) ? 31 : bs + bl / 2) : 0;
        e.busy = 32 * (18 + ((lg > 8) ? lg : 8)) + 1;
        return e;
    endfunction

    // ADC / delay-line model: readback lags the command by 'lag' cycles;
    // words are the training pattern at passing taps, corrupted otherwise.
    initial begin
        logic [4:0] hist [16];
        logic [4:0] last_tap;
        int         cyc;
        int         which;
        logic [15:0] bad;
        for (int i = 0; i < 16; i++) hist[i] = '0;
        last_tap = '0;
        cyc      = 0;
        tap_out  = '0;
        ch1 = PAT; ch2 = PAT; ch3 = PAT; ch4 = PAT;
        forever begin
            @(negedge clk);
            for (int i = 15; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = tap_in;
            tap_out = stuck ? 5'd0 : hist[lag];
            if (tap_in != last_tap) cyc = 0;
            else cyc++;
            last_tap = tap_in;
            ch1 = PAT; ch2 = PAT; ch3 = PAT; ch4 = PAT;
            if (!pass_mask[tap_out]) begin
                which = $urandom_range(0, 3);
                bad   = PAT ^ 16'($urandom_range(1, 65535));
                case (which)
                    0: ch1 = bad;
                    1: ch2 = bad;
                    2: ch3 = bad;
                    default: ch4 = bad;
                endcase
            end
            // Tap 12: SET is cycle 0, SETTLE 1..8, CHECK 9..24.
            if (glitch12 && tap_in == 5'd12 && cyc == 24)
                ch3 = PAT ^ 16'h0100;
        end
    end

    // Monitor: counts BUSY cycles and scores each result as BUSY falls.
    initial begin
        int   busy_cyc = 0;
        bit   prev = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (busy) begin
                busy_cyc++;
            end else begin
                if (prev && !rst) begin
                    check("sb_has_entry", int'(sb_q.size() > 0), 1);
                    if (sb_q.size() > 0) begin
                        e = sb_q.pop_front();
                        check("done",      int'(done),   int'(e.done));
                        check("fail",      int'(fail_o), int'(e.fail));
                        check("tap_in",    int'(tap_in), e.tap);
                        check("eye_width", int'(eye),    e.eye);
                        check("busy_cyc",  busy_cyc,     e.busy);
                    end
                    results_seen++;
                end
                busy_cyc = 0;
            end
            prev = busy;
        end
    end

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic run_cal(input logic [31:0] mask, input bit glitch, input int lg,
                           input bit stk, input bit restart);
        exp_t e;
        int   seen0;
        pass_mask = mask;
        glitch12  = glitch;
        lag       = lg;
        stuck     = stk;
        if (stk) begin
            e.done = 0; e.fail = 1; e.tap = 0; e.eye = 0;
            e.busy = 26 + 1 + 255;
        end else begin
            e = model(glitch ? (mask & ~(32'h1 << 12)) : mask, lg);
        end
        sb_q.push_back(e);
        seen0 = results_seen;
        pulse_start();
        if (restart) begin
            repeat (100) @(negedge clk);
            pulse_start();
        end
        for (int i = 0; i < 3000 && results_seen == seen0; i++) @(negedge clk);
        check("run_completed", results_seen - seen0, 1);
        if (results_seen == seen0) sb_q.delete();
        repeat (3) @(negedge clk);
        check("done_hold", int'(done),   int'(e.done));
        check("fail_hold", int'(fail_o), int'(e.fail));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] m;
        int ws, wl;
        rst   = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy",  int'(busy),   0);
        check("rst_done",  int'(done),   0);
        check("rst_fail",  int'(fail_o), 0);
        check("rst_tap",   int'(tap_in), 0);
        check("rst_eye",   int'(eye),    0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run_cal(32'hFFFF_FFFF, 0, 3, 0, 0);          // all pass: 16 / 32
        run_cal(32'h000F_FC00, 0, 0, 0, 1);          // 10..19, extra START ignored
        run_cal(32'h3FF0_0078, 0, 5, 0, 0);          // 3..6 + 20..29: 25 / 10
        run_cal(32'h01F0_00F8, 0, 1, 0, 0);          // 3..7 + 20..24: tie -> 5 / 5
        run_cal(32'hF000_0000, 0, 2, 0, 0);          // 28..31: 30 / 4
        run_cal(32'h0000_0007, 0, 4, 0, 0);          // 0..2: FAIL, 0 / 3
        run_cal(32'hFFFF_FFFF, 1, 2, 0, 0);          // glitch at tap 12 last CHECK cycle
        run_cal(32'hFFFF_FFFF, 0, 10, 0, 0);         // slow readback stretches SETTLE
        run_cal(32'hFFFF_FFFF, 0, 0, 1, 0);          // readback stuck at 0: timeout

        // Reset in the middle of a sweep
        pass_mask = 32'hFFFF_FFFF; glitch12 = 0; lag = 1; stuck = 0;
        pulse_start();
        for (int i = 0; i < 1000 && tap_in != 5'd17; i++) @(negedge clk);
        check("reached_tap17", int'(tap_in), 17);
        rst = 1'b1;
        #1;
        check("mid_rst_busy", int'(busy),   0);
        check("mid_rst_done", int'(done),   0);
        check("mid_rst_fail", int'(fail_o), 0);
        check("mid_rst_tap",  int'(tap_in), 0);
        check("mid_rst_eye",  int'(eye),    0);
        pulse_start();                               // START while in reset
        @(negedge clk) rst = 1'b0;
        repeat (4) @(negedge clk);
        check("start_in_rst_busy", int'(busy), 0);
        run_cal(32'hFFFF_FFFF, 0, 1, 0, 0);

        // Randomised masks and readback lags
        for (int r = 0; r < 4; r++) begin
            m  = $urandom & $urandom;
            ws = $urandom_range(0, 31);
            wl = $urandom_range(0, 12);
            for (int t = ws; t < ws + wl && t < 32; t++) m[t] = 1'b1;
            run_cal(m, 0, $urandom_range(0, 11), 0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_adc_tap_calib

// File: doc/adc_tap_calib.md
ADC_TAP_CALIB -- requirements
Module: adc_tap_calib

Interface
REQ-001 Parameter PATTERN, default 16'hA55A, is the ADC training word expected on every channel.
REQ-002 Parameter SETTLE_CYC, default 8, is the minimum number of wait cycles after each tap change.
REQ-003 Parameter SAMPLE_CNT, default 16, is the number of words compared per tap.
REQ-004 Parameter MIN_EYE, default 4, is the minimum passing-window width, in taps, for success.
REQ-005 Parameter TIMEOUT_CYC, default 255, is the maximum wait for tap readback before abort.
REQ-006 Port CLK_DIV_IN, in, 1: the only clock; all logic is on its rising edge.
REQ-007 Port IO_RESET, in, 1: reset, asynchronous and active-high.
REQ-008 Port START, in, 1: one-cycle calibration request.
REQ-009 Ports CH1_DATA, CH2_DATA, CH3_DATA, CH4_DATA, in, 16 each: deserialised ADC words.
REQ-010 Port IN_DELAY_TAP_OUT, in, 5: current delay tap read back from the channels.
REQ-011 Port IN_DELAY_TAP_IN, out, 5: commanded delay tap, shared by all four channels.
REQ-012 Port BUSY, out, 1: high while a sweep is in progress.
REQ-013 Port DONE, out, 1: level output, calibration succeeded.
REQ-014 Port FAIL, out, 1: level output, calibration failed.
REQ-015 Port EYE_WIDTH, out, 6: width of the best passing window (0..32).

Function
REQ-016 The FSM SHALL have the states IDLE, SET, SETTLE, CHECK, NEXT and FINISH.
REQ-017 In IDLE, START=1 SHALL clear DONE, FAIL, EYE_WIDTH and the tracker, set tap=0, and enter SET; START SHALL be ignored in every other state.
REQ-018 SET SHALL drive IN_DELAY_TAP_IN=tap for one cycle, then enter SETTLE.
REQ-019 SETTLE SHALL last at least SETTLE_CYC cycles and SHALL exit to CHECK only when IN_DELAY_TAP_OUT equals tap.
REQ-020 If the readback does not match within TIMEOUT_CYC cycles of SETTLE, the FSM SHALL set FAIL=1, set IN_DELAY_TAP_IN=0, and enter IDLE.
REQ-021 CHECK SHALL last exactly SAMPLE_CNT cycles and never abort early; the tap passes only if all four channels equal PATTERN on every one of those cycles.
REQ-022 NEXT SHALL feed the pass/fail result to the tracker; if tap=31 it SHALL enter FINISH, otherwise it SHALL increment tap and enter SET.
REQ-023 With the defaults, one tap SHALL take 1+8+16+1 = 26 cycles when the readback matches immediately.
REQ-024 Tracker: the longest run of consecutive passing taps SHALL be recorded as (best_start, best_len); a run still open at tap 31 SHALL be closed at FINISH; on equal lengths the earlier run SHALL be kept; runs SHALL NOT wrap from tap 31 to tap 0.
REQ-025 FINISH, when best_len>=MIN_EYE, SHALL set IN_DELAY_TAP_IN=best_start+floor(best_len/2) (capped at 31), EYE_WIDTH=best_len and DONE=1.
REQ-026 FINISH, when best_len<MIN_EYE, SHALL set IN_DELAY_TAP_IN=0, EYE_WIDTH=best_len and FAIL=1.
REQ-027 FINISH SHALL last one cycle and then return to IDLE.
REQ-028 BUSY SHALL be 1 in every state other than IDLE.
REQ-029 DONE and FAIL SHALL be mutually exclusive and SHALL hold until the next accepted START.

Reset
REQ-030 IO_RESET=1 SHALL, at any time including mid-sweep, force the state to IDLE and set IN_DELAY_TAP_IN=0, BUSY=0, DONE=0, FAIL=0, EYE_WIDTH=0, and clear all counters and tracker registers.
REQ-031 START SHALL have no effect while IO_RESET=1.

Structure
REQ-032 Package adc_calib_pkg SHALL hold the state enum, TAP_W=5, TAP_MAX=31 and the parameter defaults.
REQ-033 The run tracker SHALL be the single sub-module adc_eye_tracker (inputs: valid, pass, clear, close; outputs: best_start, best_len).

Verification
REQ-034 All 32 taps pass: the bench SHALL see IN_DELAY_TAP_IN=16, EYE_WIDTH=32, DONE=1, with BUSY high for 32*26+1 cycles.
REQ-035 Only taps 10..19 pass: the bench SHALL see tap 15, EYE_WIDTH=10, DONE=1.
REQ-036 Windows 3..6 and 20..29 pass, plus a second case with 3..7 and 20..24 passing: the bench SHALL see tap 25 with width 10 in the first case, and tap 5 with width 5 (tie, earlier window kept) in the second.
REQ-037 Taps 28..31 pass: the bench SHALL see tap 30 and EYE_WIDTH=4 (window closed at the end); taps 0..2 only: the bench SHALL see FAIL=1, tap 0, EYE_WIDTH=3.
REQ-038 A single mismatching word on CH3 at the last CHECK cycle of tap 12 SHALL make tap 12 fail, and CHECK SHALL still take 16 cycles.
REQ-039 Readback stuck at 0 with tap 1 commanded SHALL give FAIL after 255 SETTLE cycles; IO_RESET asserted at tap 17 SHALL give an immediate IDLE with all outputs 0, and a subsequent START SHALL sweep normally.
